// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction-fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int PC_INCR = 4;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(PC_INCR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch-stage controller steering pc_reg and the instruction-memory
//            handshake; optional misaligned-redirect trap via
//            FETCH_CTRL_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   output logic [XLEN-1:0] pc_next_o,
   output logic            pc_write_en_o,
   input  logic            stall_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   output logic            if_valid_o,
   output logic            flush_o,
   output logic            misalign_o
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] drain_tgt, drain_tgt_nxt;
   logic [XLEN-1:0] redir_tgt;
   logic            redir_mis;
   logic            mis_pulse;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
   assign redir_mis = |redirect_pc_i[1:0];
   assign redir_tgt = redir_mis ? TRAP_VEC : redirect_pc_i;
`else
   assign redir_mis = 1'b0;
   assign redir_tgt = redirect_pc_i & ~XLEN'(3);
`endif

   // The old PC is never overwritten while a request is outstanding, so pc_i
   // doubles as a stable fetch address.
   assign imem_addr_o = pc_i;
   assign misalign_o  = mis_pulse;

   always_comb begin
      state_nxt     = state;
      drain_tgt_nxt = drain_tgt;
      pc_next_o     = pc_i;
      pc_write_en_o = 1'b0;
      imem_req_o    = 1'b0;
      if_valid_o    = 1'b0;
      flush_o       = 1'b0;
      mis_pulse     = 1'b0;

      case (state)
         ST_BOOT: begin
            pc_next_o     = RESET_PC;
            pc_write_en_o = 1'b1;
            state_nxt     = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req_o = 1'b1;
            if (redirect_valid_i) begin
               flush_o   = 1'b1;
               mis_pulse = redir_mis;
               if (imem_ack_i) begin
                  pc_next_o     = redir_tgt;
                  pc_write_en_o = 1'b1;
                  state_nxt     = stall_i ? ST_HOLD : ST_FETCH;
               end else begin
                  drain_tgt_nxt = redir_tgt;
                  state_nxt     = ST_DRAIN;
               end
            end else if (imem_ack_i) begin
               if (stall_i) begin
                  state_nxt = ST_HOLD;
               end else begin
                  if_valid_o    = 1'b1;
                  pc_next_o     = seq_pc(pc_i);
                  pc_write_en_o = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (redirect_valid_i) begin
               flush_o       = 1'b1;
               mis_pulse     = redir_mis;
               pc_next_o     = redir_tgt;
               pc_write_en_o = 1'b1;
            end
            state_nxt = stall_i ? ST_HOLD : ST_FETCH;
         end
         ST_DRAIN: begin
            imem_req_o = 1'b1;
            if (redirect_valid_i) begin
               flush_o       = 1'b1;
               mis_pulse     = redir_mis;
               drain_tgt_nxt = redir_tgt;
            end
            // The in-flight fetch is wrong-path: finish it, drop it, then jump.
            if (imem_ack_i) begin
               pc_next_o     = redirect_valid_i ? redir_tgt : drain_tgt;
               pc_write_en_o = 1'b1;
               state_nxt     = stall_i ? ST_HOLD : ST_FETCH;
            end
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase

      // Request stays up this cycle; it drops once the FSM lands in BOOT.
      if (rst) begin
         state_nxt     = ST_BOOT;
         drain_tgt_nxt = '0;
         pc_next_o     = RESET_PC;
         pc_write_en_o = 1'b1;
         if_valid_o    = 1'b0;
         flush_o       = 1'b0;
         mis_pulse     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state     <= state_nxt;
      drain_tgt <= drain_tgt_nxt;
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl with a pc_reg stand-in;
//            honours FETCH_CTRL_MISALIGN_TRAP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, stall, rv, ack;
   logic [31:0] rp;
   logic [31:0] pc, pc_next, imem_addr;
   logic        pc_we, imem_req, if_valid, flush, misalign;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RST_PC), .TRAP_VEC(TRAP)) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_i             (pc),
      .pc_next_o        (pc_next),
      .pc_write_en_o    (pc_we),
      .stall_i          (stall),
      .redirect_valid_i (rv),
      .redirect_pc_i    (rp),
      .imem_req_o       (imem_req),
      .imem_addr_o      (imem_addr),
      .imem_ack_i       (ack),
      .if_valid_o       (if_valid),
      .flush_o          (flush),
      .misalign_o       (misalign)
   );

   // pc_reg sibling
   always_ff @(posedge clk) begin
      if (pc_we) pc <= pc_next;
      cyc <= cyc + 1;
   end

   // Reference model: flags describing what the fetch stage is waiting on.
   logic        m_boot = 1'b1, m_hold = 1'b0, m_drain = 1'b0;
   logic [31:0] m_ptgt = 32'h0;
   logic        n_boot, n_hold, n_drain;
   logic [31:0] n_ptgt;
   logic        e_req, e_val, e_we, e_fl, e_mi;
   logic [31:0] e_pcn;

   function automatic logic [31:0] eff_target(input logic [31:0] a);
      if (MIS_EN && (a % 4) != 0) return TRAP;
      return a - (a % 4);
   endfunction

   task automatic model_eval();
      logic [31:0] t;
      t = eff_target(rp);
      n_boot = 1'b0; n_hold = m_hold; n_drain = m_drain; n_ptgt = m_ptgt;
      e_req = 0; e_val = 0; e_we = 0; e_fl = 0; e_mi = 0; e_pcn = 32'h0;
      if (m_boot) begin
         e_we = 1; e_pcn = RST_PC;
      end else if (m_hold) begin
         if (rv) begin
            e_we = 1; e_pcn = t; e_fl = 1; e_mi = MIS_EN && (rp % 4 != 0);
         end
         n_hold = stall;
      end else begin
         e_req = 1;
         if (rv) begin
            e_fl = 1; e_mi = MIS_EN && (rp % 4 != 0);
         end
         if (ack) begin
            if (rv || m_drain) begin
               e_we = 1; e_pcn = rv ? t : m_ptgt;
               n_hold = stall; n_drain = 0;
            end else if (stall) begin
               n_hold = 1;
            end else begin
               e_val = 1; e_we = 1; e_pcn = pc + 32'd4;
            end
         end else if (rv) begin
            n_drain = 1; n_ptgt = t;
         end
      end
      if (rst) begin
         e_val = 0; e_fl = 0; e_mi = 0; e_we = 1; e_pcn = RST_PC;
         n_boot = 1; n_hold = 0; n_drain = 0; n_ptgt = 32'h0;
      end
   endtask

   task automatic model_commit();
      m_boot = n_boot; m_hold = n_hold; m_drain = n_drain; m_ptgt = n_ptgt;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic v,
                        input logic [31:0] a, input logic k);
      @(negedge clk);
      rst = r; stall = s; rv = v; rp = a; ack = k;
      #1;
      model_eval();
   endtask

   typedef struct {
      logic        rst, stall, rv;
      logic [31:0] rp;
      logic        ack, chk;
      logic        req, val, we, fl, mi;
      logic [31:0] pcn, pc;
   } vec_t;

   function automatic vec_t mk(input logic r, s, v, input logic [31:0] a, input logic k, c,
                               input logic q, vl, w, f, m, input logic [31:0] pn, p);
      vec_t x;
      x.rst = r; x.stall = s; x.rv = v; x.rp = a; x.ack = k; x.chk = c;
      x.req = q; x.val = vl; x.we = w; x.fl = f; x.mi = m; x.pcn = pn; x.pc = p;
      return x;
   endfunction

   initial begin
      vec_t        tbl[$];
      logic [31:0] p;
      logic        prev_rv;
      p = MIS_EN ? 32'h100 : 32'h200;
      rst = 1; stall = 0; rv = 0; rp = 0; ack = 0;

      //            rst s rv rp           ack chk req val we fl mi pcn          pc
      tbl.push_back(mk(1,0,0,32'h0,        0, 0, 0, 0, 1, 0, 0, 32'h0,       32'h0));
      tbl.push_back(mk(1,0,0,32'h0,        1, 1, 0, 0, 1, 0, 0, 32'h0,       32'h0));
      tbl.push_back(mk(1,0,0,32'h0,        1, 1, 0, 0, 1, 0, 0, 32'h0,       32'h0));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 0, 0, 1, 0, 0, 32'h0,       32'h0));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 1, 1, 0, 0, 32'h4,       32'h0));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 1, 1, 0, 0, 32'h8,       32'h4));
      tbl.push_back(mk(0,1,0,32'h0,        1, 1, 1, 0, 0, 0, 0, 32'h0,       32'h8));
      tbl.push_back(mk(0,1,0,32'h0,        1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h8));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h8));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 1, 1, 0, 0, 32'hC,       32'h8));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 1, 1, 0, 0, 32'h10,      32'hC));
      tbl.push_back(mk(0,0,1,32'h200,      0, 1, 1, 0, 0, 1, 0, 32'h0,       32'h10));
      tbl.push_back(mk(0,0,0,32'h0,        0, 1, 1, 0, 0, 0, 0, 32'h0,       32'h10));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 0, 1, 0, 0, 32'h200,     32'h10));
      tbl.push_back(mk(0,0,0,32'h0,        0, 1, 1, 0, 0, 0, 0, 32'h0,       32'h200));
      tbl.push_back(mk(0,0,1,32'h250,      0, 1, 1, 0, 0, 1, 0, 32'h0,       32'h200));
      tbl.push_back(mk(0,0,1,32'h300,      0, 1, 1, 0, 0, 1, 0, 32'h0,       32'h200));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 0, 1, 0, 0, 32'h300,     32'h200));
      tbl.push_back(mk(0,0,1,32'h202,      1, 1, 1, 0, 1, 1, MIS_EN, p,      32'h300));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 1, 1, 0, 0, p + 32'h4,   p));
      tbl.push_back(mk(0,0,1,32'h40,       1, 1, 1, 0, 1, 1, 0, 32'h40,      p + 32'h4));
      tbl.push_back(mk(0,0,0,32'h0,        0, 1, 1, 0, 0, 0, 0, 32'h0,       32'h40));
      tbl.push_back(mk(1,0,0,32'h0,        0, 1, 1, 0, 1, 0, 0, 32'h0,       32'h40));
      tbl.push_back(mk(0,0,0,32'h0,        0, 1, 0, 0, 1, 0, 0, 32'h0,       32'h0));
      tbl.push_back(mk(0,0,1,32'hFFFFFFFC, 1, 1, 1, 0, 1, 1, 0, 32'hFFFFFFFC,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 1, 1, 0, 0, 32'h0,       32'hFFFFFFFC));
      tbl.push_back(mk(0,1,0,32'h0,        1, 1, 1, 0, 0, 0, 0, 32'h0,       32'h0));
      tbl.push_back(mk(0,1,1,32'h500,      0, 1, 0, 0, 1, 1, 0, 32'h500,     32'h0));
      tbl.push_back(mk(0,1,0,32'h0,        1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h500));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h500));
      tbl.push_back(mk(0,0,0,32'h0,        1, 1, 1, 1, 1, 0, 0, 32'h504,     32'h500));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rp, tbl[i].ack);
         if (tbl[i].chk) begin
            chk($sformatf("v%0d_pc", i),       pc,       tbl[i].pc);
            chk($sformatf("v%0d_req", i),      32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("v%0d_valid", i),    32'(if_valid), 32'(tbl[i].val));
            chk($sformatf("v%0d_we", i),       32'(pc_we),    32'(tbl[i].we));
            chk($sformatf("v%0d_flush", i),    32'(flush),    32'(tbl[i].fl));
            chk($sformatf("v%0d_misalign", i), 32'(misalign), 32'(tbl[i].mi));
            if (tbl[i].we)  chk($sformatf("v%0d_pc_next", i), pc_next, tbl[i].pcn);
            if (tbl[i].req) chk($sformatf("v%0d_addr", i), imem_addr, pc);
         end
         model_commit();
      end

      prev_rv = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic r, s, v, k;
         logic [31:0] a;
         r = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 9) < 3);
         v = !prev_rv && ($urandom_range(0, 9) < 2);
         a = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 4095));
         k = $urandom_range(0, 1) == 1;
         prev_rv = v;
         drive(r, s, v, a, k);
         chk("rnd_req",      32'(imem_req), 32'(e_req));
         chk("rnd_valid",    32'(if_valid), 32'(e_val));
         chk("rnd_we",       32'(pc_we),    32'(e_we));
         chk("rnd_flush",    32'(flush),    32'(e_fl));
         chk("rnd_misalign", 32'(misalign), 32'(e_mi));
         if (e_we)  chk("rnd_pc_next", pc_next, e_pcn);
         if (e_req) chk("rnd_addr", imem_addr, pc);
         model_commit();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC loaded on boot.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h00000100, the misaligned-redirect target (used only with REQ-031).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_i  in  32  current PC from pc_reg.pc_o.
REQ-006 SHALL have port pc_next_o  out  32  value for pc_reg.pc_next_i.
REQ-007 SHALL have port pc_write_en_o  out  1  drives pc_reg.pc_write_en_i.
REQ-008 SHALL have port stall_i  in  1  downstream IF/ID cannot accept an instruction.
REQ-009 SHALL have port redirect_valid_i  in  1  branch/jump resolved taken, single-cycle pulse.
REQ-010 SHALL have port redirect_pc_i  in  32  redirect target, valid with redirect_valid_i.
REQ-011 SHALL have port imem_req_o  out  1  instruction-memory request.
REQ-012 SHALL have port imem_addr_o  out  32  fetch address.
REQ-013 SHALL have port imem_ack_i  in  1  fetch complete; sampled only while imem_req_o=1.
REQ-014 SHALL have port if_valid_o  out  1  fetched instruction committed to IF/ID this cycle.
REQ-015 SHALL have port flush_o  out  1  one-cycle pulse per accepted redirect.
REQ-016 SHALL have port misalign_o  out  1  misaligned-redirect pulse; tied 0 without REQ-031.

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, HOLD, DRAIN; all outputs decoded from state and current inputs.
REQ-018 BOOT: pc_next_o=RESET_PC, pc_write_en_o=1, imem_req_o=0; unconditionally next state FETCH.
REQ-019 FETCH: imem_req_o=1, imem_addr_o=pc_i; imem_addr_o and imem_req_o SHALL stay stable until imem_ack_i=1.
REQ-020 FETCH, ack=1, stall=0, no redirect: if_valid_o=1, pc_next_o=pc_i+4 (mod 2^32, 0xFFFFFFFC wraps to 0), pc_write_en_o=1, stay FETCH.
REQ-021 FETCH, ack=1, stall=1: if_valid_o=0, pc_write_en_o=0, fetch discarded, go HOLD (same PC refetched later).
REQ-022 HOLD: imem_req_o=0, pc_write_en_o=0; go FETCH in the cycle after stall_i=0.
REQ-023 Redirect priority: redirect_valid_i overrides ack/stall handling in every state except BOOT.
REQ-024 Redirect with ack=1 in FETCH: if_valid_o=0, pc_next_o=target, pc_write_en_o=1, flush_o=1; next state HOLD if stall_i=1 else FETCH.
REQ-025 Redirect with ack=0 in FETCH: latch target, flush_o=1, go DRAIN; no PC write.
REQ-026 DRAIN: imem_req_o=1 on old address until ack; on ack, if_valid_o=0, pc_next_o=latched target, pc_write_en_o=1, go FETCH (HOLD if stall_i=1).
REQ-027 Redirect in DRAIN SHALL overwrite the latched target (newest wins) and pulse flush_o; redirect coincident with DRAIN ack SHALL use the new target.
REQ-028 Redirect in HOLD: immediate PC write of target, flush_o=1, remain HOLD while stall_i=1.
REQ-029 pc_write_en_o SHALL be 0 in every cycle not listed above; if_valid_o and pc_write_en_o never assert without a defined cause.

Reset
REQ-030 While rst=1 the FSM SHALL be forced to BOOT each cycle, latched target cleared to 0; outputs in BOOT per REQ-018, if_valid_o=flush_o=misalign_o=0; reset mid-handshake abandons the request (imem_req_o drops next cycle).

Configuration
REQ-031 With FETCH_CTRL_MISALIGN_TRAP_EN defined, an accepted redirect target with bits[1:0]!=0 SHALL be replaced by TRAP_VEC and misalign_o pulse with flush_o; without it, target bits[1:0] SHALL be forced to 00 and misalign_o tied 0.

Structure
REQ-032 Package fetch_pkg SHALL hold the FSM state typedef, XLEN=32 and PC_INCR=4.
REQ-033 No sub-module; fetch_ctrl and pc_reg SHALL be siblings instantiated in the fetch stage.

Verification
REQ-034 Reset 3 cycles, release, ack every cycle -> pc_o sequence 0x0,0x4,0x8,0xC; if_valid_o=1 each ack.
REQ-035 At PC 0x8, ack with stall_i=1 for 2 cycles -> no write, HOLD, refetch 0x8, then pc_o=0xC.
REQ-036 At PC 0x10, redirect 0x200 with ack=0, ack 2 cycles later -> flush_o one pulse, if_valid_o=0, imem_addr_o stays 0x10, then pc_o=0x200.
REQ-037 In DRAIN, second redirect 0x300 -> pc_o=0x300 after ack, two flush_o pulses.
REQ-038 Redirect 0x202: with macro -> pc_o=0x100, misalign_o=1; without -> pc_o=0x200, misalign_o=0.
REQ-039 rst=1 mid-handshake at PC 0x40 -> imem_req_o=0 next cycle, pc_o=RESET_PC after release.
